// File: rtl/mult_seq_pkg.sv
// Package: mult_seq_pkg
// Shared definitions for the multiplier batch sequencer.
//  - state_t       : sequencer FSM states (IDLE, ISSUE, DRAIN, FIN)
//  - DEF_*         : default parameter values for the sequencer
//  - out_cnt_w()   : width needed by the outstanding-work counter
//  - OUT_CNT_W     : that width at the default latencies
package mult_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_PROD_W  = 32;
    localparam int DEF_RD_LAT  = 1;
    localparam int DEF_MUL_LAT = 2;

    // The counter peaks at RD_LAT+1+MUL_LAT pairs in flight, so it must be
    // able to hold that value (hence +2 inside the clog2).
    function automatic int out_cnt_w(input int rd_lat, input int mul_lat);
        return $clog2(rd_lat + mul_lat + 2);
    endfunction

    localparam int OUT_CNT_W = out_cnt_w(DEF_RD_LAT, DEF_MUL_LAT);

endpackage

// File: rtl/mult_batch_sequencer_delay.sv
// Module: valid_delay_line
// One-bit shift register used to delay valid strobes by a fixed number of
// cycles. Synchronous active-low reset clears every stage. DEPTH=0 makes it a
// plain wire.
// Ports:
//  clka   in  clock
//  rst_n  in  synchronous reset, active-low
//  din    in  valid in
//  dout   out valid delayed by DEPTH cycles
module valid_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clka,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            // Clock and reset have no job in the zero-depth case.
            logic unused_ok;
            assign unused_ok = clka ^ rst_n;
            assign dout      = din;
        end else begin : g_pipe
            logic stage_reg [DEPTH];

            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                if (gi == 0) begin : g_first
                    always_ff @(posedge clka) begin
                        if (!rst_n) begin
                            stage_reg[gi] <= 1'b0;
                        end else begin
                            stage_reg[gi] <= din;
                        end
                    end
                end else begin : g_next
                    always_ff @(posedge clka) begin
                        if (!rst_n) begin
                            stage_reg[gi] <= 1'b0;
                        end else begin
                            stage_reg[gi] <= stage_reg[gi-1];
                        end
                    end
                end
            end

            assign dout = stage_reg[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/mult_batch_sequencer.sv
// Module: mult_batch_sequencer
// Streams packed operand pairs {b,a} out of the operand BRAM into a fixed-
// latency signed multiplier and writes each product into the result BRAM at
// the same index. busy covers the whole batch; done pulses one cycle after the
// last result write; err pulses when a start carries an illegal pair count.
// Ports:
//  clka, rst_n         clock, synchronous active-low reset
//  start, pause        batch request (IDLE only) / issue hold (level)
//  num_ops             pairs in the batch, 1..2**ADDR_W, sampled on start
//  busy, done, err     status
//  rd_en, rd_addr      operand BRAM read port; rd_data returns RD_LAT later
//  op_a, op_b,op_valid multiplier operands and their strobe
//  prod                multiplier product, valid MUL_LAT cycles after op_valid
//  wr_en, wr_addr,     result BRAM write port; wr_data is prod unmodified
//  wr_data
module mult_batch_sequencer
    import mult_seq_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int PROD_W  = DEF_PROD_W,
    parameter int RD_LAT  = DEF_RD_LAT,
    parameter int MUL_LAT = DEF_MUL_LAT
) (
    input  logic                clka,
    input  logic                rst_n,
    input  logic                start,
    input  logic                pause,
    input  logic [ADDR_W:0]     num_ops,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [2*DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0]   op_a,
    output logic [DATA_W-1:0]   op_b,
    output logic                op_valid,
    input  logic [PROD_W-1:0]   prod,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [PROD_W-1:0]   wr_data
);

    localparam int OW = out_cnt_w(RD_LAT, MUL_LAT);
    localparam logic [ADDR_W:0] MAX_OPS = {1'b1, {ADDR_W{1'b0}}};

    state_t          state_reg;
    logic [ADDR_W:0] count_reg;
    logic [ADDR_W:0] issued_reg;
    logic [OW-1:0]   outstanding_reg;
    logic [OW-1:0]   outstanding_next;
    logic            rd_vld;
    logic            num_ops_ok;

    assign num_ops_ok = (num_ops != '0) && (num_ops <= MAX_OPS);

    // Outstanding pairs: read issued but result not yet written.
    always_comb begin
        outstanding_next = outstanding_reg;
        if (rd_en && !wr_en) begin
            outstanding_next = outstanding_reg + OW'(1);
        end else if (!rd_en && wr_en) begin
            outstanding_next = outstanding_reg - OW'(1);
        end
    end

    // Read-return pipe: rd_vld marks the cycle rd_data carries a requested pair.
    valid_delay_line #(
        .DEPTH (RD_LAT)
    ) u_rd_pipe (
        .clka  (clka),
        .rst_n (rst_n),
        .din   (rd_en),
        .dout  (rd_vld)
    );

    // Operand capture register; operands hold between valids.
    always_ff @(posedge clka) begin
        if (!rst_n) begin
            op_a     <= '0;
            op_b     <= '0;
            op_valid <= 1'b0;
        end else begin
            op_valid <= rd_vld;
            if (rd_vld) begin
                op_a <= rd_data[DATA_W-1:0];
                op_b <= rd_data[2*DATA_W-1:DATA_W];
            end
        end
    end

    // Write pipe: the multiplier never stalls, so a fixed delay of op_valid
    // lines up with prod exactly.
    valid_delay_line #(
        .DEPTH (MUL_LAT)
    ) u_wr_pipe (
        .clka  (clka),
        .rst_n (rst_n),
        .din   (op_valid),
        .dout  (wr_en)
    );

    assign wr_data = prod;

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clka) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            count_reg       <= '0;
            issued_reg      <= '0;
            outstanding_reg <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            rd_en           <= 1'b0;
            rd_addr         <= '0;
            wr_addr         <= '0;
        end else begin
            done            <= 1'b0;
            err             <= 1'b0;
            rd_en           <= 1'b0;
            outstanding_reg <= outstanding_next;

            // Addresses advance after the cycle that used them.
            if (rd_en) begin
                rd_addr <= rd_addr + 1'b1;
            end
            if (wr_en) begin
                wr_addr <= wr_addr + 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (num_ops_ok) begin
                            count_reg  <= num_ops;
                            issued_reg <= '0;
                            rd_addr    <= '0;
                            wr_addr    <= '0;
                            busy       <= 1'b1;
                            state_reg  <= ISSUE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (!pause) begin
                        rd_en      <= 1'b1;
                        issued_reg <= issued_reg + 1'b1;
                        // The last read is still on the bus during the
                        // first DRAIN cycle; the counter catches it there.
                        if (issued_reg + 1'b1 == count_reg) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Looking at the next value lets done follow the final
                    // write by exactly one cycle.
                    if (outstanding_next == '0) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= FIN;
                    end
                end
                FIN: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
